// File: rtl/core_pkg.sv
// Types and constants shared by the fetch unit and branch control.
package core_pkg;

   typedef enum logic [1:0] {
      S_REQ  = 2'd0,
      S_WAIT = 2'd1,
      S_HOLD = 2'd2
   } fetch_state_e;

   // pc_src_a: sequential flow vs. take the computed target
   localparam logic PC_SRC_A_SEQ    = 1'b0;
   localparam logic PC_SRC_A_TARGET = 1'b1;
   // pc_src_b: target base is the resolving PC or rs1
   localparam logic PC_SRC_B_PC     = 1'b0;
   localparam logic PC_SRC_B_RS1    = 1'b1;

   // Width of the count of killed responses still in flight
   localparam int KILL_W = 2;

endpackage

// File: rtl/pc_target_calc.sv
// Redirect target adder: base + imm, with bit 0 cleared for register-relative jumps.
module pc_target_calc
   import core_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            pc_src_b_i,
   input  logic [XLEN-1:0] ex_pc_i,
   input  logic [XLEN-1:0] rs1_i,
   input  logic [XLEN-1:0] imm_i,
   output logic [XLEN-1:0] target_o
);

   logic [XLEN-1:0] base;
   logic [XLEN-1:0] sum;

   always_comb begin
      base     = (pc_src_b_i == PC_SRC_B_RS1) ? rs1_i : ex_pc_i;
      sum      = base + imm_i;
      target_o = sum;
      if (pc_src_b_i == PC_SRC_B_RS1) target_o[0] = 1'b0;
   end

endmodule

// File: rtl/pc_fetch.sv
// Single-outstanding instruction fetch: PC register, request FSM and a one-entry
// output buffer to decode, with redirect and stale-response kill handling.
module pc_fetch
   import core_pkg::*;
#(
   parameter int              XLEN     = 32,
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            redirect_valid,
   input  logic            pc_src_a,
   input  logic            pc_src_b,
   input  logic [XLEN-1:0] ex_pc,
   input  logic [XLEN-1:0] rs1,
   input  logic [XLEN-1:0] imm,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_gnt,
   input  logic            imem_rvalid,
   input  logic [31:0]     imem_rdata,
   output logic            if_valid,
   output logic [XLEN-1:0] if_pc,
   output logic [31:0]     if_instr,
   input  logic            if_ready
);

   fetch_state_e      state_q;
   logic [XLEN-1:0]   pc_q;
   logic [KILL_W-1:0] kill_q, kill_d;
   logic              if_valid_q;
   logic [XLEN-1:0]   if_pc_q;
   logic [31:0]       if_instr_q;

   logic              redir;
   logic [XLEN-1:0]   target;
   logic              live_rvalid;
   logic              kill_inc;
   logic              kill_dec;

   pc_target_calc #(.XLEN(XLEN)) u_target (
      .pc_src_b_i (pc_src_b),
      .ex_pc_i    (ex_pc),
      .rs1_i      (rs1),
      .imm_i      (imm),
      .target_o   (target)
   );

   assign redir       = redirect_valid & (pc_src_a == PC_SRC_A_TARGET);
   assign live_rvalid = imem_rvalid & (kill_q == '0);

   // Responses owed to abandoned requests are counted, not just flagged, so a
   // grant-plus-redirect in S_REQ followed by another redirect still drops both.
   always_comb begin
      kill_inc = redir & (((state_q == S_REQ) & imem_gnt) |
                          ((state_q == S_WAIT) & ~live_rvalid));
      kill_dec = imem_rvalid & (kill_q != '0);
      kill_d   = kill_q + {{(KILL_W-1){1'b0}}, kill_inc} - {{(KILL_W-1){1'b0}}, kill_dec};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_REQ;
         pc_q       <= RESET_PC;
         kill_q     <= '0;
         if_valid_q <= 1'b0;
         if_pc_q    <= '0;
         if_instr_q <= '0;
      end else begin
         kill_q <= kill_d;
         case (state_q)
            S_REQ: begin
               if (redir)         pc_q    <= target;
               else if (imem_gnt) state_q <= S_WAIT;
            end
            S_WAIT: begin
               if (redir) begin
                  pc_q    <= target;
                  state_q <= S_REQ;
               end else if (live_rvalid) begin
                  if_valid_q <= 1'b1;
                  if_pc_q    <= pc_q;
                  if_instr_q <= imem_rdata;
                  state_q    <= S_HOLD;
               end
            end
            S_HOLD: begin
               if (redir) begin
                  pc_q       <= target;
                  if_valid_q <= 1'b0;
                  state_q    <= S_REQ;
               end else if (if_ready) begin
                  pc_q       <= pc_q + XLEN'(4);
                  if_valid_q <= 1'b0;
                  state_q    <= S_REQ;
               end
            end
            default: state_q <= S_REQ;
         endcase
      end
   end

   assign imem_req  = (state_q == S_REQ);
   assign imem_addr = pc_q;
   assign if_valid  = if_valid_q;
   assign if_pc     = if_pc_q;
   assign if_instr  = if_instr_q;

endmodule
